gpio_btn_led: RTL

Memory-mapped GPIO peripheral for the RISC-V core. It gives the core parametrised LED outputs and debounced active-low button inputs. It sits on the core's data-memory bus as a word-addressed slave. It synchronises and debounces every button, latches press events into write-1-to-clear pending bits, and can raise a level interrupt. It replaces direct wiring of the button and LED pins into the core.

---
 rtl/gpio_btn_led.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gpio_btn_led.sv
// gpio_btn_led: word-addressed GPIO slave with LED outputs and debounced active-low buttons.
// Define GPIO_IRQ_EN to build the PEND (W1C) / IRQ_EN registers and the o_irq logic.
module gpio_btn_led #(
  parameter int N_BTN           = 1,
  parameter int N_LED           = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_button,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [3:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic [N_LED-1:0] o_led,
  output logic             o_irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REG_LED    = 2'd0;
  localparam logic [1:0] REG_BTN    = 2'd1;
  localparam logic [1:0] REG_PEND   = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  logic [1:0]       reg_sel;
  logic             wr_led;
  logic [N_LED-1:0] led_out;
  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] irq_en;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign reg_sel     = i_addr[3:2];
  assign wr_led      = i_we && (reg_sel == REG_LED);
  assign unused_bits = ^{i_addr[1:0], i_wdata};

  // Stage p0/p1: two-flop synchroniser, idles at "released"
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= i_button;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             stable_r;
    logic             differ;
    logic             accept;

    assign differ    = (sync_p1[g] != stable_r);
    assign accept    = differ && (cnt == CNT_LAST);
    assign press[g]  = accept && stable_r;
    assign stable[g] = stable_r;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt      <= '0;
        stable_r <= 1'b1;
      end else if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        cnt      <= '0;
        stable_r <= sync_p1[g];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
    end else if (wr_led) begin
      led_out <= i_wdata[N_LED-1:0];
    end
  end

  assign o_led = led_out;

`ifdef GPIO_IRQ_EN
  logic             wr_pend;
  logic             wr_irq_en;
  logic [N_BTN-1:0] w1c_mask;

  assign wr_pend   = i_we && (reg_sel == REG_PEND);
  assign wr_irq_en = i_we && (reg_sel == REG_IRQ_EN);
  assign w1c_mask  = wr_pend ? i_wdata[N_BTN-1:0] : '0;

  // A press landing on the same edge as its W1C keeps the bit set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend   <= '0;
      irq_en <= '0;
    end else begin
      pend <= (pend & ~w1c_mask) | press;
      if (wr_irq_en) begin
        irq_en <= i_wdata[N_BTN-1:0];
      end
    end
  end

  assign o_irq = |(pend & irq_en);
`else
  logic unused_press;

  assign unused_press = ^press;
  assign pend         = '0;
  assign irq_en       = '0;
  assign o_irq        = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_LED:    rd_mux[N_LED-1:0] = led_out;
      REG_BTN:    rd_mux[N_BTN-1:0] = stable;
      REG_PEND:   rd_mux[N_BTN-1:0] = pend;
      REG_IRQ_EN: rd_mux[N_BTN-1:0] = irq_en;
      default:    rd_mux = '0;
    endcase
  end

  // Read data is sampled from pre-write register state, so read-during-write sees the old value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= rd_mux;
    end
  end

endmodule
